// File: rtl/sub8u_approx_pipe.sv
// rtl/sub8u_approx_pipe.sv - two-stage approximate 8-bit unsigned subtractor with error statistics
// High bits are subtracted exactly; the low APPROX_LSB bits pass A through, with no borrow.
module sub8u_approx_pipe #(
   parameter int APPROX_LSB = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [8:0]  O,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        stats_clr,
   output logic [7:0]  err_max,
   output logic [23:0] err_sum,
   output logic [15:0] err_cnt
);

   localparam logic [7:0] LOW_MASK = 8'((16'd1 << APPROX_LSB) - 16'd1);

   logic        r_s1_valid;
   logic [7:0]  r_s1_a;
   logic [7:0]  r_s1_b;
   logic [8:0]  r_s1_hdiff;
   logic        r_s2_valid;
   logic [8:0]  r_o;
   logic [7:0]  r_err;
   logic [7:0]  r_max;
   logic [23:0] r_sum;
   logic [15:0] r_cnt;

   logic        w_s2_load;
   logic        w_s1_load;
   logic        w_in_xfer;
   logic        w_out_xfer;
   logic [7:0]  w_ah;
   logic [7:0]  w_bh;
   logic [8:0]  w_hdiff;
   logic [8:0]  w_o;
   logic [8:0]  w_e;
   logic [8:0]  w_d9;
   logic [7:0]  w_err;
   logic [24:0] w_sum_next;

   assign w_s2_load  = !r_s2_valid || out_ready;
   assign w_s1_load  = !r_s1_valid || w_s2_load;
   assign in_ready   = rst_n && w_s1_load;
   assign out_valid  = rst_n && r_s2_valid;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   // High-part difference only; its 9-bit result shifted by k is the (9-k)-bit field O[8:k].
   assign w_ah    = A >> APPROX_LSB;
   assign w_bh    = B >> APPROX_LSB;
   assign w_hdiff = {1'b0, w_ah} - {1'b0, w_bh};

   assign w_o = 9'(r_s1_hdiff << APPROX_LSB) | {1'b0, r_s1_a & LOW_MASK};
   assign w_e = {1'b0, r_s1_a} - {1'b0, r_s1_b};
   // True error magnitude is below 2^k <= 128, so 9-bit wraparound arithmetic is exact.
   assign w_d9  = w_o - w_e;
   assign w_err = w_d9[8] ? 8'(8'd0 - w_d9[7:0]) : w_d9[7:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= 8'd0;
         r_s1_b     <= 8'd0;
         r_s1_hdiff <= 9'd0;
         r_s2_valid <= 1'b0;
         r_o        <= 9'd0;
         r_err      <= 8'd0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= in_valid;
         end
         if (w_in_xfer) begin
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_hdiff <= w_hdiff;
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s2_load && r_s1_valid) begin
            r_o   <= w_o;
            r_err <= w_err;
         end
      end
   end

   assign w_sum_next = {1'b0, r_sum} + {17'd0, r_err};

   always_ff @(posedge clk) begin
      if (!rst_n || stats_clr) begin
         r_max <= 8'd0;
         r_sum <= 24'd0;
         r_cnt <= 16'd0;
      end else if (w_out_xfer) begin
         r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
         r_sum <= w_sum_next[24] ? 24'hFF_FFFF : w_sum_next[23:0];
         if (r_err > r_max) begin
            r_max <= r_err;
         end
      end
   end

   assign O       = r_o;
   assign err_max = r_max;
   assign err_sum = r_sum;
   assign err_cnt = r_cnt;

endmodule

// File: doc/sub8u_approx_pipe.md
SUB8U_APPROX_PIPE -- requirements
Module: sub8u_approx_pipe

Interface
REQ-001 Parameter APPROX_LSB, default 2, number of low result bits computed approximately; legal range 0..7, where 0 gives exact subtraction.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port A, input, 8 bits: unsigned minuend.
REQ-005 Port B, input, 8 bits: unsigned subtrahend.
REQ-006 Port in_valid, input, 1 bit: A/B valid.
REQ-007 Port in_ready, output, 1 bit: block accepts A/B this cycle.
REQ-008 Port O, output, 9 bits: approximate difference, two's complement, O[8] = sign/borrow.
REQ-009 Port out_valid, output, 1 bit: O valid.
REQ-010 Port out_ready, input, 1 bit: consumer accepts O.
REQ-011 Port stats_clr, input, 1 bit: synchronous clear of error statistics.
REQ-012 Port err_max, output, 8 bits: worst-case absolute error since last clear.
REQ-013 Port err_sum, output, 24 bits: sum of absolute errors since last clear, saturating.
REQ-014 Port err_cnt, output, 16 bits: transferred results since last clear, saturating.

Function
REQ-015 Let k = APPROX_LSB, Ah = A[7:k], Bh = B[7:k]; O[8:k] shall equal the (9-k)-bit two's complement of Ah - Bh, with no borrow-in.
REQ-016 O[k-1:0] shall equal A[k-1:0] (pass-through, no low-part borrow generated); for k = 0, O = A - B exactly.
REQ-017 Exact reference E = A - B (signed); error = |signed9(O) - E|, computed in the pipeline, always < 2^k, and held in 8 bits.
REQ-018 Two-stage pipeline: stage 1 registers the operands and the high-part difference; stage 2 registers O and the error.
REQ-019 Each stage holds a valid bit; stage 2 loads when empty or out_ready=1; stage 1 loads when empty or stage 2 loads.
REQ-020 in_ready = !s1_valid || s2_load, combinational; an input transfer occurs on in_valid && in_ready.
REQ-021 An output transfer occurs on out_valid && out_ready; with out_ready held at 1, latency from accept to out_valid is exactly 2 cycles, throughput 1 per cycle.
REQ-022 While out_valid=1 and out_ready=0, O shall be held stable; bubbles between stages collapse.
REQ-023 On each output transfer: err_cnt += 1, err_sum += error, and err_max = max(err_max, error); err_cnt and err_sum saturate at all-ones, with no wrap.
REQ-024 stats_clr=1 zeroes err_max, err_sum and err_cnt next cycle and takes priority over a simultaneous transfer, whose sample is not counted.
REQ-025 stats_clr shall not affect the pipeline or the handshake.

Reset
REQ-026 rst_n=0 at a clock edge clears both stage valid bits and zeroes O, err_max, err_sum and err_cnt.
REQ-027 While rst_n=0, in_ready=0 and out_valid=0; any transactions in flight when reset asserts mid-operation are discarded.
REQ-028 First input acceptance is possible in the first cycle after rst_n returns to 1.

Verification
REQ-029 k=2, A=0x10, B=0x03, out_ready=1 -> 2 cycles later O=0x010, error=3, err_max=3, err_cnt=1, err_sum=3.
REQ-030 k=2, A=0x03, B=0x05 -> O=0x1FF (-1), error=1; then A=0xFF, B=0x00 -> O=0x0FF, error=0; err_max stays 3 if run after REQ-029.
REQ-031 k=0, 256 random pairs -> O == A-B for every result; err_max=0, err_sum=0, err_cnt=256.
REQ-032 Stream of 4 inputs with out_ready=0 -> in_ready drops after 2 accepts, O holds its first value; release out_ready -> all 4 results appear in order, none lost or duplicated.
REQ-033 stats_clr asserted in the same cycle as an output transfer -> next cycle all statistics are 0, and that sample is not counted.
REQ-034 rst_n asserted with both stages full -> next cycle out_valid=0 and all statistics are 0; no stale result appears after rst_n is released.
